// File: rtl/ber_counter_if.sv
// ber_counter_if
//   Bundles the BER checker's symbol inputs and result outputs.
//   master : drives enable/valid/reference/received bits, reads the results.
//   slave  : the BER checker itself.
// Signals
//   enable, valid                  BER enable level and symbol strobe
//   ref_r, ref_i, rx_r, rx_i       reference and received hard bits
//   bit_count_r/_i, error_count_r/_i  LOG_COUNT_LEN-bit result counters
//   aligned                        high while counting after lock
//   delay_r, delay_i               locked delay per channel
interface ber_counter_if #(
  parameter int DELAY_LEN     = 512,
  parameter int LOG_COUNT_LEN = 64
);
  localparam int DELAY_W = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;

  logic                     enable;
  logic                     valid;
  logic                     ref_r;
  logic                     ref_i;
  logic                     rx_r;
  logic                     rx_i;
  logic [LOG_COUNT_LEN-1:0] bit_count_r;
  logic [LOG_COUNT_LEN-1:0] bit_count_i;
  logic [LOG_COUNT_LEN-1:0] error_count_r;
  logic [LOG_COUNT_LEN-1:0] error_count_i;
  logic                     aligned;
  logic [DELAY_W-1:0]       delay_r;
  logic [DELAY_W-1:0]       delay_i;

  modport master (
    output enable, valid, ref_r, ref_i, rx_r, rx_i,
    input  bit_count_r, bit_count_i, error_count_r, error_count_i,
    input  aligned, delay_r, delay_i
  );

  modport slave (
    input  enable, valid, ref_r, ref_i, rx_r, rx_i,
    output bit_count_r, bit_count_i, error_count_r, error_count_i,
    output aligned, delay_r, delay_i
  );
endinterface

// File: rtl/ber_counter.sv
// ber_counter
//   QPSK bit-error-rate checker. Finds the channel delay by a minimum-error
//   search over DELAY_LEN candidate delays (SEARCH_WINDOW valid symbols each),
//   then accumulates saturating bit and error counts per channel.
// Ports
//   clk  : single clock
//   rst  : synchronous active-high reset
//   bus  : ber_counter_if.slave (enable, valid, ref/rx bits in; counts,
//          aligned, delay_r/delay_i out). All outputs are registered.
// Build option
//   BER_IM_SEARCH_EN : when defined, the imaginary channel runs its own
//   minimum tracker and locks delay_i independently; otherwise delay_i
//   follows delay_r.
module ber_counter #(
  parameter int DELAY_LEN     = 512,
  parameter int SEARCH_WINDOW = 1024,
  parameter int LOG_COUNT_LEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  ber_counter_if.slave bus
);
  localparam int DELAY_W = (DELAY_LEN > 1) ? $clog2(DELAY_LEN) : 1;
  localparam int WIN_W   = $clog2(SEARCH_WINDOW + 1);
  localparam int HIST_W  = DELAY_LEN - 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;

  localparam logic [DELAY_W-1:0]       D_ZERO    = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0]       LAST_CAND = DELAY_W'(DELAY_LEN - 1);
  localparam logic [WIN_W-1:0]         W_ZERO    = {WIN_W{1'b0}};
  localparam logic [WIN_W-1:0]         LAST_WIN  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [LOG_COUNT_LEN-1:0] C_ZERO    = {LOG_COUNT_LEN{1'b0}};
  localparam logic [HIST_W-1:0]        H_ZERO    = {HIST_W{1'b0}};

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [LOG_COUNT_LEN-1:0] sat_inc(
    input logic [LOG_COUNT_LEN-1:0] val,
    input logic                     inc
  );
    if (inc && (val != {LOG_COUNT_LEN{1'b1}})) begin
      sat_inc = val + LOG_COUNT_LEN'(1);
    end else begin
      sat_inc = val;
    end
  endfunction

  logic [1:0]               state_r;
  logic                     aligned_r;
  logic [HIST_W-1:0]        hist_re_r;
  logic [HIST_W-1:0]        hist_im_r;
  logic [DELAY_LEN-1:0]     tap_re_s;
  logic [DELAY_LEN-1:0]     tap_im_s;
  logic [DELAY_W-1:0]       cand_r;
  logic [WIN_W-1:0]         win_cnt_r;
  logic [WIN_W-1:0]         win_err_re_r;
  logic [WIN_W-1:0]         min_err_re_r;
  logic [DELAY_W-1:0]       best_re_r;
  logic [DELAY_W-1:0]       delay_re_r;
  logic [DELAY_W-1:0]       delay_im_sel_s;
  logic [WIN_W-1:0]         win_err_nxt_re_s;
  logic                     win_last_s;
  logic                     take_re_s;
  logic                     cnt_mis_re_s;
  logic                     cnt_mis_im_s;
  logic [LOG_COUNT_LEN-1:0] bit_cnt_re_r;
  logic [LOG_COUNT_LEN-1:0] bit_cnt_im_r;
  logic [LOG_COUNT_LEN-1:0] err_cnt_re_r;
  logic [LOG_COUNT_LEN-1:0] err_cnt_im_r;

  // Tap vector: tap 0 is the current reference bit, tap d the bit d valids ago.
  always_comb begin
    tap_re_s = {hist_re_r, bus.ref_r};
    tap_im_s = {hist_im_r, bus.ref_i};
  end

  // Search scoring for the current candidate and count-phase mismatches.
  always_comb begin
    win_err_nxt_re_s = win_err_re_r + WIN_W'(bus.rx_r ^ tap_re_s[cand_r]);
    win_last_s       = (win_cnt_r == LAST_WIN);
    // Candidate 0 always seeds the minimum; later ones must be strictly better.
    take_re_s        = (cand_r == D_ZERO) || (win_err_nxt_re_s < min_err_re_r);
    cnt_mis_re_s     = bus.rx_r ^ tap_re_s[delay_re_r];
    cnt_mis_im_s     = bus.rx_i ^ tap_im_s[delay_im_sel_s];
  end

  // Reference delay lines: shift on every valid regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_re_r <= H_ZERO;
      hist_im_r <= H_ZERO;
    end else if (bus.valid) begin
      hist_re_r <= tap_re_s[DELAY_LEN-2:0];
      hist_im_r <= tap_im_s[DELAY_LEN-2:0];
    end
  end

  // Control FSM, real-channel minimum search and the four result counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      aligned_r    <= 1'b0;
      cand_r       <= D_ZERO;
      win_cnt_r    <= W_ZERO;
      win_err_re_r <= W_ZERO;
      min_err_re_r <= W_ZERO;
      best_re_r    <= D_ZERO;
      delay_re_r   <= D_ZERO;
      bit_cnt_re_r <= C_ZERO;
      bit_cnt_im_r <= C_ZERO;
      err_cnt_re_r <= C_ZERO;
      err_cnt_im_r <= C_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          aligned_r <= 1'b0;
          // The entry cycle only clears; its valid symbol is not scored.
          if (bus.enable) begin
            state_r      <= ST_SEARCH;
            cand_r       <= D_ZERO;
            win_cnt_r    <= W_ZERO;
            win_err_re_r <= W_ZERO;
            min_err_re_r <= W_ZERO;
            best_re_r    <= D_ZERO;
            bit_cnt_re_r <= C_ZERO;
            bit_cnt_im_r <= C_ZERO;
            err_cnt_re_r <= C_ZERO;
            err_cnt_im_r <= C_ZERO;
          end
        end
        ST_SEARCH: begin
          if (!bus.enable) begin
            state_r   <= ST_IDLE;
            aligned_r <= 1'b0;
          end else if (bus.valid) begin
            if (win_last_s) begin
              win_cnt_r    <= W_ZERO;
              win_err_re_r <= W_ZERO;
              if (take_re_s) begin
                min_err_re_r <= win_err_nxt_re_s;
                best_re_r    <= cand_r;
              end
              if (cand_r == LAST_CAND) begin
                state_r    <= ST_COUNT;
                aligned_r  <= 1'b1;
                delay_re_r <= take_re_s ? cand_r : best_re_r;
              end else begin
                cand_r <= cand_r + DELAY_W'(1);
              end
            end else begin
              win_cnt_r    <= win_cnt_r + WIN_W'(1);
              win_err_re_r <= win_err_nxt_re_s;
            end
          end
        end
        ST_COUNT: begin
          if (!bus.enable) begin
            state_r   <= ST_IDLE;
            aligned_r <= 1'b0;
          end else if (bus.valid) begin
            bit_cnt_re_r <= sat_inc(bit_cnt_re_r, 1'b1);
            bit_cnt_im_r <= sat_inc(bit_cnt_im_r, 1'b1);
            err_cnt_re_r <= sat_inc(err_cnt_re_r, cnt_mis_re_s);
            err_cnt_im_r <= sat_inc(err_cnt_im_r, cnt_mis_im_s);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          aligned_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef BER_IM_SEARCH_EN
  logic [WIN_W-1:0]   win_err_im_r;
  logic [WIN_W-1:0]   min_err_im_r;
  logic [DELAY_W-1:0] best_im_r;
  logic [DELAY_W-1:0] delay_im_r;
  logic [WIN_W-1:0]   win_err_nxt_im_s;
  logic               take_im_s;

  // Imaginary-channel scoring against the same candidate as the real channel.
  always_comb begin
    win_err_nxt_im_s = win_err_im_r + WIN_W'(bus.rx_i ^ tap_im_s[cand_r]);
    take_im_s        = (cand_r == D_ZERO) || (win_err_nxt_im_s < min_err_im_r);
    delay_im_sel_s   = delay_im_r;
  end

  // Imaginary-channel minimum tracker, stepping in lock with the real one.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_err_im_r <= W_ZERO;
      min_err_im_r <= W_ZERO;
      best_im_r    <= D_ZERO;
      delay_im_r   <= D_ZERO;
    end else if (state_r == ST_IDLE) begin
      if (bus.enable) begin
        win_err_im_r <= W_ZERO;
        min_err_im_r <= W_ZERO;
        best_im_r    <= D_ZERO;
      end
    end else if ((state_r == ST_SEARCH) && bus.enable && bus.valid) begin
      if (win_last_s) begin
        win_err_im_r <= W_ZERO;
        if (take_im_s) begin
          min_err_im_r <= win_err_nxt_im_s;
          best_im_r    <= cand_r;
        end
        if (cand_r == LAST_CAND) begin
          delay_im_r <= take_im_s ? cand_r : best_im_r;
        end
      end else begin
        win_err_im_r <= win_err_nxt_im_s;
      end
    end
  end

  assign bus.delay_i = delay_im_r;
`else
  // Without its own tracker the imaginary channel reuses the real lock.
  always_comb begin
    delay_im_sel_s = delay_re_r;
  end

  assign bus.delay_i = delay_re_r;
`endif

  assign bus.bit_count_r   = bit_cnt_re_r;
  assign bus.bit_count_i   = bit_cnt_im_r;
  assign bus.error_count_r = err_cnt_re_r;
  assign bus.error_count_i = err_cnt_im_r;
  assign bus.aligned       = aligned_r;
  assign bus.delay_r       = delay_re_r;
endmodule
